axi_burst_write_master: RTL and testbench

AXI4-style write-burst master that loads the multi-read-port AXI memory. It accepts a load command (base address, burst count) and a valid/ready word stream. It issues one INCR burst of `BURST_BEATS` words per burst on AW/W/B, advancing the address by `BURST_BEATS` each time, and drives the memory's `W_EN`. It sits directly upstream of the memory's write channels, replacing the bench-driven write sequence in the accelerator datapath.

---
 rtl/axi_wr_pkg.sv | 15 +
 rtl/axi_w_out_slice.sv | 57 +++++
 rtl/axi_burst_write_master.sv | 142 ++++++++++++++
 tb/tb_axi_burst_write_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_pkg.sv
// Shared types and AXI encodings for the burst write master.
package axi_wr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_DONE
    } wm_state_t;

    localparam logic       AXI_BURST_INCR = 1'b1;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_w_out_slice.sv
// Single-entry W output register: holds one beat until the slave takes it,
// accepting a new beat in the same cycle the current one drains.
module axi_w_out_slice #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  last_in,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;

    assign in_ready = !valid_q || out_ready;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
            last_d  = last_in;
        end else if (out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            // NOTE: the payload is reset as well so WDATA reads 0 out of reset.
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

endmodule

// File: rtl/axi_burst_write_master.sv
// AXI4 INCR write-burst master: turns a (base, nbursts) command plus a word
// stream into fixed-length bursts on AW/W/B and drives the memory write enable.
module axi_burst_write_master
    import axi_wr_pkg::*;
#(
    parameter int W_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int BURST_BEATS  = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [W_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]              cmd_nbursts,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [W_ADDR_WIDTH-1:0] AWADDR,
    output logic                    AWBURST,
    output logic [7:0]              AWLEN,
    output logic                    WVALID,
    input  logic                    WREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic                    WLAST,
    input  logic                    BVALID,
    output logic                    BREADY,
    input  logic [1:0]              BRESP,
    output logic                    W_EN,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int                    CNT_W     = 9;
    localparam logic [CNT_W-1:0]      BEATS_CNT = CNT_W'(BURST_BEATS);
    localparam logic [W_ADDR_WIDTH-1:0] ADDR_STEP = W_ADDR_WIDTH'(BURST_BEATS);
    localparam logic [7:0]            AXI_LEN   = 8'(BURST_BEATS - 1);

    wm_state_t               state_q, state_d;
    logic [W_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]              left_q, left_d;
    logic [CNT_W-1:0]        loaded_q, loaded_d;
    logic                    err_q, err_d;
    logic                    cmd_ready_q, awvalid_q, bready_q, w_en_q, busy_q, done_q;

    logic slice_in_ready;
    logic s_fire;

    // The slice only fills during DATA and never beyond one burst's worth.
    assign s_ready = (state_q == ST_DATA) && slice_in_ready && (loaded_q < BEATS_CNT);
    assign s_fire  = s_valid && s_ready;

    axi_w_out_slice #(.DATA_WIDTH(DATA_WIDTH)) u_w_slice (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .in_valid  (s_fire),
        .in_ready  (slice_in_ready),
        .in_data   (s_data),
        .last_in   (loaded_q == BEATS_CNT - 1'b1),
        .out_valid (WVALID),
        .out_data  (WDATA),
        .out_last  (WLAST),
        .out_ready (WREADY)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        left_d   = left_q;
        loaded_d = loaded_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: if (cmd_valid && cmd_ready_q) begin
                addr_d  = cmd_addr;
                left_d  = cmd_nbursts;
                err_d   = 1'b0;
                state_d = (cmd_nbursts == 8'd0) ? ST_DONE : ST_ADDR;
            end
            ST_ADDR: if (awvalid_q && AWREADY) begin
                loaded_d = '0;
                state_d  = ST_DATA;
            end
            ST_DATA: begin
                if (s_fire) loaded_d = loaded_q + 1'b1;
                if (WVALID && WREADY && WLAST) state_d = ST_RESP;
            end
            ST_RESP: if (bready_q && BVALID) begin
                err_d   = err_q || (BRESP != AXI_RESP_OKAY);
                left_d  = left_q - 8'd1;
                addr_d  = addr_q + ADDR_STEP;
                state_d = (left_q == 8'd1) ? ST_DONE : ST_ADDR;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake-facing outputs are registered from the next state, so no
    // valid ever depends combinationally on its ready.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            left_q      <= '0;
            loaded_q    <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            w_en_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            left_q      <= left_d;
            loaded_q    <= loaded_d;
            err_q       <= err_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            awvalid_q   <= (state_d == ST_ADDR);
            bready_q    <= (state_d == ST_RESP);
            w_en_q      <= (state_d == ST_ADDR) || (state_d == ST_DATA) || (state_d == ST_RESP);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign AWVALID   = awvalid_q;
    assign AWADDR    = awvalid_q ? addr_q : '0;
    assign AWBURST   = awvalid_q ? AXI_BURST_INCR : 1'b0;
    assign AWLEN     = awvalid_q ? AXI_LEN : 8'd0;
    assign BREADY    = bready_q;
    assign W_EN      = w_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_axi_burst_write_master.sv
// Scoreboard bench for axi_burst_write_master: stream words are queued as they
// are offered and matched against W beats; a memory model collects the writes.
module tb_axi_burst_write_master;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int BEATS = 32;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_nbursts;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          AWVALID, AWREADY, AWBURST;
    logic [AW-1:0] AWADDR;
    logic [7:0]    AWLEN;
    logic          WVALID, WREADY, WLAST;
    logic [DW-1:0] WDATA;
    logic          BVALID, BREADY;
    logic [1:0]    BRESP;
    logic          W_EN, busy, done, err;

    axi_burst_write_master #(.W_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_BEATS(BEATS)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_nbursts(cmd_nbursts),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWBURST(AWBURST), .AWLEN(AWLEN),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .W_EN(W_EN), .busy(busy), .done(done), .err(err)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard and bench state
    logic [DW-1:0] exp_w[$];
    logic [AW-1:0] aw_exp[$];
    logic [1:0]    resp_q[$];
    logic [DW-1:0] mem[1024];
    int            src_idx, src_n, b_pending, done_cnt, bursts_done, w_beats, beat;
    logic [DW-1:0] src_base, stall_data;
    logic [AW-1:0] cur_addr, last_awaddr;
    logic          s_fire_f, b_fire_f, stall_prev, aw_open, act_seen;
    logic          gap_en, wready_rand, awready_rand;

    function automatic logic [63:0] outs_vec();
        return 64'({AWVALID, AWADDR, AWBURST, AWLEN, WVALID, WDATA, WLAST,
                    BREADY, W_EN, busy, done, err, s_ready});
    endfunction

    // Monitor: sampled on the falling edge, i.e. between active edges.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            s_fire_f   = 1'b0;
            b_fire_f   = 1'b0;
            stall_prev = 1'b0;
            aw_open    = 1'b0;
        end else begin
            s_fire_f = s_valid & s_ready;
            b_fire_f = BVALID & BREADY;
            if (AWVALID | WVALID | BREADY | W_EN) act_seen = 1'b1;
            if (done) done_cnt++;
            if (stall_prev) begin
                check("w_hold_valid", 64'(WVALID), 64'd1);
                check("w_hold_data", 64'(WDATA), 64'(stall_data));
            end
            stall_prev = WVALID & !WREADY;
            stall_data = WDATA;
            if (AWVALID && AWREADY) begin
                if (aw_exp.size() == 0) check("aw_extra", 64'd1, 64'd0);
                else check("awaddr", 64'(AWADDR), 64'(aw_exp.pop_front()));
                check("awlen", 64'(AWLEN), 64'(BEATS - 1));
                check("awburst", 64'(AWBURST), 64'd1);
                cur_addr    = AWADDR;
                last_awaddr = AWADDR;
                beat        = 0;
                aw_open     = 1'b1;
            end
            if (WVALID) check("w_after_aw", 64'(aw_open), 64'd1);
            if (WVALID && WREADY) begin
                if (exp_w.size() == 0) check("w_extra", 64'd1, 64'd0);
                else check("wdata", 64'(WDATA), 64'(exp_w.pop_front()));
                check("wlast", 64'(WLAST), 64'(beat == BEATS - 1));
                mem[cur_addr + AW'(beat)] = WDATA;
                beat++;
                w_beats++;
                if (WLAST) begin
                    aw_open = 1'b0;
                    b_pending++;
                end
            end
            if (BVALID && BREADY) bursts_done++;
        end
    end

    // Bus-functional driver: updates all slave/source inputs 1 time unit after the edge.
    always begin
        @(posedge ACLK);
        #1;
        if (!ARESETn) begin
            s_valid = 1'b0;
            BVALID  = 1'b0;
        end else begin
            if (s_fire_f) begin
                s_valid = 1'b0;
                src_idx++;
            end
            if (!s_valid && src_idx < src_n && (!gap_en || $urandom_range(0, 2) != 0)) begin
                s_valid = 1'b1;
                s_data  = src_base + DW'(src_idx);
                exp_w.push_back(s_data);
            end
            WREADY  = wready_rand  ? 1'($urandom_range(0, 1)) : 1'b1;
            AWREADY = awready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_fire_f) BVALID = 1'b0;
            if (!BVALID && b_pending > 0) begin
                b_pending--;
                BVALID = 1'b1;
                BRESP  = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
            end
        end
    end

    task automatic start_cmd(input logic [AW-1:0] a, input logic [7:0] nb, input int words,
                             input logic [DW-1:0] dbase);
        src_base = dbase;
        src_idx  = 0;
        src_n    = words;
        for (int i = 0; i < int'(nb); i++) aw_exp.push_back(a + AW'(i * BEATS));
        for (int c = 0; c < 100 && !cmd_ready; c++) @(posedge ACLK);
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_addr    = a;
        cmd_nbursts = nb;
        cmd_valid   = 1'b1;
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [AW-1:0] a, input logic [7:0] nb, input int words,
                           input logic [DW-1:0] dbase);
        int d0;
        d0 = done_cnt;
        start_cmd(a, nb, words, dbase);
        for (int c = 0; c < 6000 && done_cnt == d0; c++) @(posedge ACLK);
        check("cmd_done", 64'(done_cnt - d0), 64'd1);
        repeat (2) @(posedge ACLK);
        #1;
        check("w_queue_empty", 64'(exp_w.size()), 64'd0);
        check("aw_queue_empty", 64'(aw_exp.size()), 64'd0);
    endtask

    initial begin
        int b0, d0;
        ARESETn = 1'b0;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_nbursts = '0;
        s_valid = 1'b0; s_data = '0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        src_idx = 0; src_n = 0; src_base = '0; b_pending = 0; done_cnt = 0;
        bursts_done = 0; w_beats = 0; beat = 0; cur_addr = '0; last_awaddr = '0;
        stall_data = '0; s_fire_f = 1'b0; b_fire_f = 1'b0; stall_prev = 1'b0;
        aw_open = 1'b0; act_seen = 1'b0;
        gap_en = 1'b0; wready_rand = 1'b0; awready_rand = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        repeat (3) @(posedge ACLK);
        #1;
        check("reset_outputs", outs_vec(), 64'd0);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge ACLK);
        #2 ARESETn = 1'b1;

        // Full load: 32 bursts, words 1..1024
        b0 = bursts_done; d0 = done_cnt;
        run_cmd(10'd0, 8'd32, 1024, 32'd1);
        for (int a = 0; a < 1024; a++) check("mem_full", 64'(mem[a]), 64'(a + 1));
        check("full_bursts", 64'(bursts_done - b0), 64'd32);
        check("full_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("full_err", 64'(err), 64'd0);

        // Backpressure on W and AW, gappy stream
        gap_en = 1'b1; wready_rand = 1'b1; awready_rand = 1'b1;
        b0 = bursts_done;
        run_cmd(10'd100, 8'd2, 64, 32'd5000);
        check("bp_bursts", 64'(bursts_done - b0), 64'd2);
        check("bp_mem_first", 64'(mem[100]), 64'd5000);
        check("bp_mem_last", 64'(mem[163]), 64'd5063);
        gap_en = 1'b0; wready_rand = 1'b0; awready_rand = 1'b0;

        // Error on the 2nd of 3 bursts
        resp_q.push_back(2'b00); resp_q.push_back(2'b10); resp_q.push_back(2'b00);
        b0 = bursts_done;
        run_cmd(10'd0, 8'd3, 96, 32'd9000);
        check("err_bursts", 64'(bursts_done - b0), 64'd3);
        check("err_sticky", 64'(err), 64'd1);
        check("err_mem_last", 64'(mem[95]), 64'd9095);

        // Zero bursts: done right after accept, err cleared, no AXI activity
        act_seen = 1'b0;
        cmd_addr = 10'd5; cmd_nbursts = 8'd0; cmd_valid = 1'b1;
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b0;
        check("zero_done", 64'(done), 64'd1);
        check("zero_err_clear", 64'(err), 64'd0);
        check("zero_cmd_ready_low", 64'(cmd_ready), 64'd0);
        @(posedge ACLK);
        #1;
        check("zero_done_pulse", 64'(done), 64'd0);
        check("zero_cmd_ready_back", 64'(cmd_ready), 64'd1);
        repeat (2) @(posedge ACLK);
        check("zero_no_activity", 64'(act_seen), 64'd0);

        // Address wrap
        run_cmd(10'd992, 8'd2, 64, 32'd300);
        check("wrap_awaddr", 64'(last_awaddr), 64'd0);
        check("wrap_mem_hi", 64'(mem[992]), 64'd300);
        check("wrap_mem_lo", 64'(mem[0]), 64'd332);

        // Reset in the middle of the first burst
        b0 = w_beats;
        start_cmd(10'd0, 8'd2, 64, 32'd8000);
        for (int c = 0; c < 500 && (w_beats - b0) < 10; c++) @(posedge ACLK);
        check("rst_reached_beat10", 64'((w_beats - b0) >= 10), 64'd1);
        @(negedge ACLK);
        #2 ARESETn = 1'b0;
        #1;
        check("rst_outputs", outs_vec(), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        src_n = 0; src_idx = 0; b_pending = 0;
        exp_w.delete(); aw_exp.delete(); resp_q.delete();
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        #2 ARESETn = 1'b1;
        check("rst_cmd_ready_after", 64'(cmd_ready), 64'd1);
        b0 = bursts_done;
        run_cmd(10'd64, 8'd1, 32, 32'd7000);
        check("rst_new_bursts", 64'(bursts_done - b0), 64'd1);
        check("rst_new_mem_first", 64'(mem[64]), 64'd7000);
        check("rst_new_mem_last", 64'(mem[95]), 64'd7031);
        check("rst_new_err", 64'(err), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
